// File: rtl/rv_utils_pkg.sv
// Shared routing constants for the stream demux and its buffer slots.
// Select polarity matches the 2-to-1 datapath mux: 1 routes to A, 0 to B.
package rv_utils_pkg;

  localparam int   DATA_WIDTH = 32;
  localparam logic SEL_A      = 1'b1;
  localparam logic SEL_B      = 1'b0;

  // True when the select value steers the word to output A.
  function automatic logic sel_is_a(input logic sel);
    return (sel == SEL_A);
  endfunction

endpackage

// File: rtl/demux2_slot.sv
// One output buffer of the stream demux: push/pop, occupancy and slot_free.
// Optional feature macro: DEMUX2_STREAM_SKID_EN (2-entry head+skid buffer
// with a registered full flag; otherwise a 1-entry buffer whose slot_free
// looks through to out_ready).
module demux2_slot
  import rv_utils_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             slot_free
);

`ifdef DEMUX2_STREAM_SKID_EN

  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             pop;

  assign pop       = head_valid_q && out_ready;
  assign out_valid = head_valid_q;
  assign out_data  = head_q;
  // Full flag is the skid occupancy flop, so no path from out_ready.
  assign slot_free = !skid_valid_q;

  // Next-state for head and skid entries; the head always drains first.
  always_comb begin
    head_valid_d = head_valid_q;
    head_d       = head_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    case ({push, pop})
      2'b10: begin
        if (!head_valid_q) begin
          head_valid_d = 1'b1;
          head_d       = push_data;
        end else begin
          skid_valid_d = 1'b1;
          skid_d       = push_data;
        end
      end
      2'b01: begin
        if (skid_valid_q) begin
          head_d       = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          head_valid_d = 1'b0;
        end
      end
      2'b11: begin
        // Skid is normally empty here; if not, keep order by shifting.
        if (skid_valid_q) begin
          head_d = skid_q;
          skid_d = push_data;
        end else begin
          head_d = push_data;
        end
      end
      default: begin
        head_valid_d = head_valid_q;
      end
    endcase
  end

  // Buffer registers, emptied and zeroed by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      head_q       <= {WIDTH{1'b0}};
      skid_valid_q <= 1'b0;
      skid_q       <= {WIDTH{1'b0}};
    end else begin
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

`else

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign out_valid = valid_q;
  assign out_data  = data_q;
  // Single entry: free when empty or being popped this cycle.
  assign slot_free = !valid_q || out_ready;

  // Next-state for the single entry; a push wins over a same-cycle pop.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (push) begin
      valid_d = 1'b1;
      data_d  = push_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Buffer register, emptied and zeroed by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`endif

endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demux: in_sel=1 steers to A, 0 to B.
// Each output has its own buffer so the consumers stall independently.
// Optional feature macro: DEMUX2_STREAM_SKID_EN (see demux2_slot).
module demux2_stream
  import rv_utils_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data
);

  logic a_free;
  logic b_free;
  logic sel_a;
  logic accept;
  logic push_a;
  logic push_b;

  // Ready only looks at the selected slot; held low throughout reset.
  assign sel_a    = sel_is_a(in_sel);
  assign in_ready = !rst && (sel_a ? a_free : b_free);
  assign accept   = in_valid && in_ready;
  assign push_a   = accept && sel_a;
  assign push_b   = accept && (in_sel == SEL_B);

  demux2_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .push_data (in_data),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .out_data  (a_data),
    .slot_free (a_free)
  );

  demux2_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .push_data (in_data),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .out_data  (b_data),
    .slot_free (b_free)
  );

endmodule

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream with a per-output scoreboard.
module tb_demux2_stream;

`ifdef DEMUX2_STREAM_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [31:0] in_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] popped;
  logic        stab_a_armed = 1'b0;
  logic        stab_b_armed = 1'b0;
  logic [31:0] prev_a_data  = 32'h0;
  logic [31:0] prev_b_data  = 32'h0;

  demux2_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: samples on the falling edge, i.e. the state that the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (stab_a_armed) begin
        total++;
        if (a_valid !== 1'b1 || a_data !== prev_a_data) begin
          bad++;
          $display("FAIL a_stable: valid=%b data=%h want valid=1 data=%h", a_valid, a_data, prev_a_data);
        end
      end
      if (stab_b_armed) begin
        total++;
        if (b_valid !== 1'b1 || b_data !== prev_b_data) begin
          bad++;
          $display("FAIL b_stable: valid=%b data=%h want valid=1 data=%h", b_valid, b_data, prev_b_data);
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel) exp_a.push_back(in_data);
        else        exp_b.push_back(in_data);
      end
      if (a_valid && a_ready) begin
        total++;
        if (exp_a.size() == 0) begin
          bad++;
          $display("FAIL a_order: got %h, expected nothing", a_data);
        end else begin
          popped = exp_a.pop_front();
          if (a_data !== popped) begin
            bad++;
            $display("FAIL a_order: got %h want %h", a_data, popped);
          end
        end
      end
      if (b_valid && b_ready) begin
        total++;
        if (exp_b.size() == 0) begin
          bad++;
          $display("FAIL b_order: got %h, expected nothing", b_data);
        end else begin
          popped = exp_b.pop_front();
          if (b_data !== popped) begin
            bad++;
            $display("FAIL b_order: got %h want %h", b_data, popped);
          end
        end
      end
    end
    stab_a_armed <= !rst && a_valid && !a_ready;
    stab_b_armed <= !rst && b_valid && !b_ready;
    prev_a_data  <= a_data;
    prev_b_data  <= b_data;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || a_valid !== 1'b0 || b_valid !== 1'b0 ||
        a_data !== 32'h0 || b_data !== 32'h0) begin
      bad++;
      $display("FAIL %s: in_ready=%b a_valid=%b b_valid=%b a_data=%h b_data=%h want all 0",
               tag, in_ready, a_valid, b_valid, a_data, b_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hDEAD_BEEF;
    a_ready = 1'b1; b_ready = 1'b1;
    next_cycle();
    check_reset_values("reset_hold");
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_sel = s[0];
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_release: in_ready=%b sel=%0d want 1", in_ready, s);
      end
      next_cycle();
    end
  endtask

  task automatic test_routing();
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h1111_1111;
    next_cycle();
    in_sel = 1'b0; in_data = 32'h2222_2222;
    @(negedge clk);
    total++;
    if (a_valid !== 1'b1 || a_data !== 32'h1111_1111) begin
      bad++;
      $display("FAIL route_a: valid=%b data=%h want 1 11111111", a_valid, a_data);
    end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (b_valid !== 1'b1 || b_data !== 32'h2222_2222 || a_valid !== 1'b0) begin
      bad++;
      $display("FAIL route_b: b_valid=%b b_data=%h a_valid=%b want 1 22222222 0", b_valid, b_data, a_valid);
    end
    next_cycle();
  endtask

  task automatic test_independent_stall();
    int accepted = 0;
    idle(2);
    b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0000_00B0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      if (in_ready) accepted++;
      next_cycle();
    end
    @(negedge clk);
    total++;
    if (accepted != DEPTH || in_ready !== 1'b0 || b_valid !== 1'b1) begin
      bad++;
      $display("FAIL b_full: accepted=%0d in_ready=%b b_valid=%b want %0d 0 1", accepted, in_ready, b_valid, DEPTH);
    end
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      in_sel = 1'b1; in_data = 32'hA0 + 32'(i);
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL a_while_b_stalled: word %0d in_ready=%b want 1", i, in_ready);
      end
      next_cycle();
    end
    in_valid = 1'b0;
    next_cycle();
    b_ready = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();
    total++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      bad++;
      $display("FAIL stall_drain: left a=%0d b=%0d want 0 0", exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_full_rate();
    idle(2);
    for (int k = 1; k <= 18; k++) begin
      in_valid = (k <= 16); in_sel = 1'b1; in_data = 32'h5000_0000 + 32'(k);
      @(negedge clk);
      total++;
      if ((k <= 16 && in_ready !== 1'b1) || a_valid !== (k >= 2 && k <= 17)) begin
        bad++;
        $display("FAIL full_rate: cycle %0d in_ready=%b a_valid=%b want 1 %b", k, in_ready, a_valid, (k >= 2 && k <= 17));
      end
      next_cycle();
    end
  endtask

`ifdef DEMUX2_STREAM_SKID_EN
  task automatic test_skid();
    int idx = 0;
    idle(2);
    for (int c = 0; c < 10; c++) begin
      a_ready = (c != 3); in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hC0 + 32'(idx);
      @(negedge clk);
      total++;
      if (in_ready !== (c != 4)) begin
        bad++;
        $display("FAIL skid_ready: cycle %0d in_ready=%b want %b", c, in_ready, (c != 4));
      end
      if (in_ready) idx++;
      next_cycle();
    end
    idle(3);
    total++;
    if (exp_a.size() != 0 || idx != 9) begin
      bad++;
      $display("FAIL skid_drain: left=%0d accepted=%0d want 0 9", exp_a.size(), idx);
    end
  endtask
`endif

  task automatic test_mid_reset();
    a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      in_sel = i[0]; in_data = $urandom;
      next_cycle();
    end
    for (int s = 0; s < 2; s++) begin
      in_sel = s[0];
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || a_valid !== 1'b1 || b_valid !== 1'b1) begin
        bad++;
        $display("FAIL both_full: sel=%0d in_ready=%b a_valid=%b b_valid=%b want 0 1 1", s, in_ready, a_valid, b_valid);
      end
      next_cycle();
    end
    rst = 1'b1;
    check_reset_values("mid_reset");
    next_cycle();
    rst = 1'b0; in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1; in_sel = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_release: in_ready=%b a_valid=%b b_valid=%b want 1 0 0", in_ready, a_valid, b_valid);
    end
    next_cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(1, 0) != 0);
      in_sel   = ($urandom_range(1, 0) != 0);
      in_data  = $urandom;
      a_ready  = ($urandom_range(3, 0) != 0);
      b_ready  = ($urandom_range(3, 0) != 0);
      next_cycle();
    end
    idle(6);
    total++;
    if (exp_a.size() != 0 || exp_b.size() != 0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
      bad++;
      $display("FAIL random_drain: left a=%0d b=%0d a_valid=%b b_valid=%b want 0 0 0 0",
               exp_a.size(), exp_b.size(), a_valid, b_valid);
    end
  endtask

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 32'h0;
    a_ready = 1'b0; b_ready = 1'b0;
    next_cycle();
    test_reset();
    test_routing();
    test_independent_stall();
    test_full_rate();
`ifdef DEMUX2_STREAM_SKID_EN
    test_skid();
`endif
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
# demux2_stream

Registered 1-to-2 demultiplexer for 32-bit data with valid/ready handshakes on every side. It is the counterpart of the 2-to-1 datapath mux: one producer is steered to one of two consumers, for example routing pipeline store/writeback traffic to RAM or to the MMIO path. Each output owns a small holding buffer, so the two consumers stall independently. Output ordering is preserved per output; there is no ordering guarantee between outputs.

## Interface
Parameters:
- WIDTH, 32, data width of every payload.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  demux accepts the word this cycle.
- in_sel  input  1  route select: 1 selects output A, 0 selects output B (same polarity as mux2).
- in_data  input  WIDTH  payload.
- a_valid / b_valid  output  1  output holds a word.
- a_ready / b_ready  input  1  consumer takes the word.
- a_data / b_data  output  WIDTH  head-of-buffer payload.

## Operation
- Handshake rule:
  - A transfer occurs on a rising edge where valid && ready.
  - in_sel and in_data are sampled only on the accept edge.
  - Once x_valid is high, it stays high and x_data stays stable until the x_ready transfer.
- Acceptance: in_ready = slot_free(in_sel).
  - in_ready may depend on in_sel. It never depends on the other output's state.
  - A word bound for A is never blocked by a stalled B, and vice versa.
- Accept with in_sel=1 writes the A buffer. Accept with in_sel=0 writes the B buffer.
- Simultaneous push and pop on the same buffer: both take effect in that cycle and occupancy is unchanged.
- Pops on A and B in the same cycle are independent.
- Reset, including mid-operation: buffers are emptied and any pending words are discarded.
  - a_valid=0, b_valid=0.
  - a_data=0, b_data=0.
  - in_ready follows the empty-slot rule, so it is 1 once reset is released.

## Timing
- Latency: accept on edge N gives x_valid=1 with that data after edge N. There is no combinational in-to-out path.
- Throughput: one word per cycle per output while the consumer holds ready=1.
- Without the skid buffer, slot_free(x) = !x_valid || x_ready. This is a combinational path from x_ready to in_ready.
- With the skid buffer, slot_free(x) = !x_full, and x_full is registered. There is no combinational path from x_ready.
- While rst is high: in_ready=0, and all outputs are at their reset values.

## Configuration
- Macro: DEMUX2_STREAM_SKID_EN.
- Undefined:
  - Each output buffer is 1 entry.
  - in_ready has the combinational x_ready path.
  - Full rate is sustained.
- Defined:
  - Each output buffer is 2 entries: head plus skid register.
  - x_full means 2 entries are occupied, and is registered.
  - Full rate is sustained.
  - A buffer holding 2 entries drains the head first. On pop, the skid entry moves to the head.
  - A push into a full buffer cannot occur, because in_ready=0.

## Structure
- Shared package rv_utils_pkg holds:
  - SEL_A = 1'b1 and SEL_B = 1'b0.
  - DATA_WIDTH = 32.
- Sub-module demux2_slot, instantiated twice (A and B):
  - Holds one buffer with its push/pop and occupancy logic, plus the macro-dependent depth.
  - Exports slot_free.
- The top level contains only select decode and ready muxing.

## Test plan
- Reset checks:
  - Assert rst mid-stream while both buffers are full. Expect a_valid=b_valid=0, a_data=b_data=0, and in_ready=0 during reset.
  - Release reset. Expect in_ready=1 on the next cycle.
- Routing:
  - Send 0x1111_1111 with sel=1, then 0x2222_2222 with sel=0, with both readies held at 1.
  - Expect a_data=0x1111_1111 one cycle after its accept, and b_data=0x2222_2222 one cycle after its accept.
- Independent stall:
  - Hold b_ready=0 and push 0xB0 with sel=0 until B is full. Expect in_ready=0 for sel=0.
  - Then stream 0xA0..0xA7 with sel=1. Expect all 8 words accepted at 1 per cycle and delivered in order on A.
- Full-rate push/pop: hold a_ready=1 and stream 16 words with sel=1. Expect in_ready=1 every cycle, and a_valid high from cycle 2 to cycle 17.
- Skid build only:
  - Drop a_ready for 1 cycle during a stream. Expect no word lost, in_ready to fall only after the 2nd buffered word, and A order preserved.
  - Check that in_ready never toggles in the same cycle as a_ready.
- Random traffic:
  - Drive random valid, sel, and readies for 10k cycles.
  - Scoreboard each output's sequence against its expected order, checking no loss and no duplication.
  - Assert data stability while valid && !ready.
